alu_operand_collector: RTL and testbench
========================================

ALU_OPERAND_COLLECTOR -- requirements
Module: alu_operand_collector

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST, input, 1: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have port CE, input, 1: clock enable; when low, all state, counters and outputs hold.
REQ-004 SHALL have ports in_opa (W) and in_opa_vld (1), inputs: operand A and its valid.
REQ-005 SHALL have ports in_opb (W) and in_opb_vld (1), inputs: operand B and its valid.
REQ-006 SHALL have ports in_cmd (N), in_mode (1) and in_cin (1), inputs: command, mode and carry-in for the pending operation.
REQ-007 SHALL have ports in_rdy_a and in_rdy_b, outputs, 1 each: slot A or B can accept.
REQ-008 SHALL have ports OPA and OPB (W each), CMD (N), mode, Cin, inp_valid (2) and issue (1), outputs: registered ALU-facing operation; issue is a one-cycle strobe.
REQ-009 SHALL have port TMO, output, 1: the current issue was forced by timeout.
REQ-010 SHALL take W and N from the shared defines file.

Function
REQ-011 SHALL implement FSM states IDLE, WAIT_A (B held, A missing), WAIT_B (A held, B missing) and ISSUE.
REQ-012 SHALL drive in_rdy_a = CE && (IDLE || WAIT_A) and in_rdy_b = CE && (IDLE || WAIT_B); both low in ISSUE.
REQ-013 SHALL treat an operand as accepted when its vld and rdy are high on the same edge.
REQ-014 SHALL capture in_cmd, in_mode and in_cin only on the edge the first operand is accepted from IDLE, ignoring them afterwards.
REQ-015 SHALL move IDLE->ISSUE when both operands are accepted on the same edge, IDLE->WAIT_B on A only, and IDLE->WAIT_A on B only.
REQ-016 SHALL move WAIT_A->ISSUE on A acceptance and WAIT_B->ISSUE on B acceptance.
REQ-017 SHALL have ISSUE last exactly one CE-enabled cycle, then return to IDLE.
REQ-018 SHALL in ISSUE drive issue=1 and inp_valid={B present, A present}, with 2'b11 for a normal issue.
REQ-019 SHALL outside ISSUE drive issue=0, inp_valid=2'b00 and TMO=0, with OPA, OPB, CMD, mode and Cin holding their last issued values.
REQ-020 SHALL give a latency of one cycle from the final operand's acceptance edge to issue=1.
REQ-021 SHALL clear a 5-bit wait counter on entering WAIT_A/WAIT_B and increment it on each CE-high cycle spent there.
REQ-022 SHALL give the missing operand's arrival precedence if it coincides with the counter reaching 16.
REQ-023 SHALL, when CE is low mid-wait, neither advance the counter nor accept operands.

Reset
REQ-024 SHALL, when RST=0 on an edge, force state IDLE, counter 0, OPA/OPB/CMD/mode/Cin 0, inp_valid 2'b00, issue 0 and TMO 0, regardless of CE.
REQ-025 SHALL, on reset mid-operation, discard any held operand and command without issuing.
REQ-026 SHALL hold in_rdy_a and in_rdy_b low during the reset cycle.

Configuration
REQ-027 SHALL, with COLLECT_TIMEOUT_EN defined, move WAIT_x->ISSUE with the missing operand driven 0, inp_valid 2'b01 (A only) or 2'b10 (B only) and TMO=1, when the counter reaches 16 with no arrival.
REQ-028 SHALL, without COLLECT_TIMEOUT_EN, omit the counter, never assert TMO, and wait indefinitely in WAIT_x.

Verification
REQ-029 SHALL cover: A=8'h12 and B=8'h34 together, CMD=0 -> next cycle issue=1, inp_valid=11, OPA=12, OPB=34, then IDLE.
REQ-030 SHALL cover: A=8'h05, then B=8'h07 three cycles later -> issue one cycle after B, inp_valid=11, CMD equal to the value captured with A.
REQ-031 SHALL cover (COLLECT_TIMEOUT_EN): B only, no A for 16 cycles -> issue with inp_valid=10, OPA=0, TMO=1; A arriving on the 16th cycle instead gives inp_valid=11 and TMO=0.
REQ-032 SHALL cover: CE low for 5 cycles while in WAIT_B -> rdy low, counter frozen; timeout slips by 5 cycles.
REQ-033 SHALL cover: RST=0 while in WAIT_A -> next cycle IDLE, all outputs 0, no issue pulse.
REQ-034 SHALL cover: new operands presented during ISSUE -> in_rdy_a/b=0, operands not accepted until IDLE.

Source files
------------

// File: rtl/alu_operand_collector.sv
// ============================================================================
// Module      : alu_operand_collector
// Description : Collects operand A/B plus command into one registered ALU issue
//               strobe; optional wait timeout enabled by COLLECT_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ALU_OPC_W
`define ALU_OPC_W 8
`endif
`ifndef ALU_OPC_N
`define ALU_OPC_N 4
`endif

module alu_operand_collector #(
   parameter int W = `ALU_OPC_W,
   parameter int N = `ALU_OPC_N
) (
   input  logic         clk,
   input  logic         RST,
   input  logic         CE,
   input  logic [W-1:0] in_opa,
   input  logic         in_opa_vld,
   input  logic [W-1:0] in_opb,
   input  logic         in_opb_vld,
   input  logic [N-1:0] in_cmd,
   input  logic         in_mode,
   input  logic         in_cin,
   output logic         in_rdy_a,
   output logic         in_rdy_b,
   output logic [W-1:0] OPA,
   output logic [W-1:0] OPB,
   output logic [N-1:0] CMD,
   output logic         mode,
   output logic         Cin,
   output logic [1:0]   inp_valid,
   output logic         issue,
   output logic         TMO
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT_A = 2'd1,
      S_WAIT_B = 2'd2,
      S_ISSUE  = 2'd3
   } state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   hold_a_q, hold_a_d;
   logic [W-1:0]   hold_b_q, hold_b_d;
   logic [N-1:0]   hold_cmd_q, hold_cmd_d;
   logic           hold_mode_q, hold_mode_d;
   logic           hold_cin_q, hold_cin_d;
   logic [W-1:0]   opa_q, opa_d;
   logic [W-1:0]   opb_q, opb_d;
   logic [N-1:0]   cmd_q, cmd_d;
   logic           mode_q, mode_d;
   logic           cin_q, cin_d;
   logic [1:0]     vld_q, vld_d;
   logic           issue_q, issue_d;
   logic           tmo_q, tmo_d;
`ifdef COLLECT_TIMEOUT_EN
   logic [4:0]     cnt_q, cnt_d;
`endif

   logic           acc_a, acc_b;
   logic           fire;
   logic [W-1:0]   f_opa, f_opb;
   logic [N-1:0]   f_cmd;
   logic           f_mode, f_cin, f_tmo;
   logic [1:0]     f_vld;

   // Ready is suppressed while reset is asserted so nothing looks accepted.
   assign in_rdy_a = CE && RST && (state_q == S_IDLE || state_q == S_WAIT_A);
   assign in_rdy_b = CE && RST && (state_q == S_IDLE || state_q == S_WAIT_B);
   assign acc_a    = in_opa_vld && in_rdy_a;
   assign acc_b    = in_opb_vld && in_rdy_b;

   always_comb begin
      state_d     = state_q;
      hold_a_d    = hold_a_q;
      hold_b_d    = hold_b_q;
      hold_cmd_d  = hold_cmd_q;
      hold_mode_d = hold_mode_q;
      hold_cin_d  = hold_cin_q;
      opa_d       = opa_q;
      opb_d       = opb_q;
      cmd_d       = cmd_q;
      mode_d      = mode_q;
      cin_d       = cin_q;
      vld_d       = vld_q;
      issue_d     = issue_q;
      tmo_d       = tmo_q;
`ifdef COLLECT_TIMEOUT_EN
      cnt_d       = cnt_q;
`endif
      fire        = 1'b0;
      f_opa       = '0;
      f_opb       = '0;
      f_cmd       = hold_cmd_q;
      f_mode      = hold_mode_q;
      f_cin       = hold_cin_q;
      f_vld       = 2'b00;
      f_tmo       = 1'b0;

      if (CE) begin
         case (state_q)
            S_IDLE: begin
               if (acc_a || acc_b) begin
                  hold_cmd_d  = in_cmd;
                  hold_mode_d = in_mode;
                  hold_cin_d  = in_cin;
               end
               if (acc_a && acc_b) begin
                  fire   = 1'b1;
                  f_opa  = in_opa;
                  f_opb  = in_opb;
                  f_cmd  = in_cmd;
                  f_mode = in_mode;
                  f_cin  = in_cin;
                  f_vld  = 2'b11;
               end else if (acc_a) begin
                  hold_a_d = in_opa;
                  state_d  = S_WAIT_B;
`ifdef COLLECT_TIMEOUT_EN
                  cnt_d    = '0;
`endif
               end else if (acc_b) begin
                  hold_b_d = in_opb;
                  state_d  = S_WAIT_A;
`ifdef COLLECT_TIMEOUT_EN
                  cnt_d    = '0;
`endif
               end
            end
            S_WAIT_A: begin
               // An arrival on the timeout edge wins over the timeout.
               if (acc_a) begin
                  fire  = 1'b1;
                  f_opa = in_opa;
                  f_opb = hold_b_q;
                  f_vld = 2'b11;
               end
`ifdef COLLECT_TIMEOUT_EN
               else if (cnt_q == 5'd15) begin
                  fire  = 1'b1;
                  f_opb = hold_b_q;
                  f_vld = 2'b10;
                  f_tmo = 1'b1;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
`endif
            end
            S_WAIT_B: begin
               if (acc_b) begin
                  fire  = 1'b1;
                  f_opa = hold_a_q;
                  f_opb = in_opb;
                  f_vld = 2'b11;
               end
`ifdef COLLECT_TIMEOUT_EN
               else if (cnt_q == 5'd15) begin
                  fire  = 1'b1;
                  f_opa = hold_a_q;
                  f_vld = 2'b01;
                  f_tmo = 1'b1;
               end else begin
                  cnt_d = cnt_q + 5'd1;
               end
`endif
            end
            S_ISSUE: begin
               state_d = S_IDLE;
               issue_d = 1'b0;
               vld_d   = 2'b00;
               tmo_d   = 1'b0;
            end
            default: state_d = S_IDLE;
         endcase

         if (fire) begin
            state_d = S_ISSUE;
            opa_d   = f_opa;
            opb_d   = f_opb;
            cmd_d   = f_cmd;
            mode_d  = f_mode;
            cin_d   = f_cin;
            vld_d   = f_vld;
            tmo_d   = f_tmo;
            issue_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!RST) begin
         state_q     <= S_IDLE;
         hold_a_q    <= '0;
         hold_b_q    <= '0;
         hold_cmd_q  <= '0;
         hold_mode_q <= 1'b0;
         hold_cin_q  <= 1'b0;
         opa_q       <= '0;
         opb_q       <= '0;
         cmd_q       <= '0;
         mode_q      <= 1'b0;
         cin_q       <= 1'b0;
         vld_q       <= 2'b00;
         issue_q     <= 1'b0;
         tmo_q       <= 1'b0;
`ifdef COLLECT_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         hold_a_q    <= hold_a_d;
         hold_b_q    <= hold_b_d;
         hold_cmd_q  <= hold_cmd_d;
         hold_mode_q <= hold_mode_d;
         hold_cin_q  <= hold_cin_d;
         opa_q       <= opa_d;
         opb_q       <= opb_d;
         cmd_q       <= cmd_d;
         mode_q      <= mode_d;
         cin_q       <= cin_d;
         vld_q       <= vld_d;
         issue_q     <= issue_d;
         tmo_q       <= tmo_d;
`ifdef COLLECT_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   assign OPA       = opa_q;
   assign OPB       = opb_q;
   assign CMD       = cmd_q;
   assign mode      = mode_q;
   assign Cin       = cin_q;
   assign inp_valid = vld_q;
   assign issue     = issue_q;
   assign TMO       = tmo_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_collector.sv
// ============================================================================
// Module      : tb_alu_operand_collector
// Description : Directed plus randomized bench for alu_operand_collector,
//               checked every cycle against a slot-occupancy reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ALU_OPC_W
`define ALU_OPC_W 8
`endif
`ifndef ALU_OPC_N
`define ALU_OPC_N 4
`endif

module tb_alu_operand_collector;
   localparam int W = `ALU_OPC_W;
   localparam int N = `ALU_OPC_N;

   logic         clk = 1'b0;
   logic         RST, CE;
   logic [W-1:0] in_opa, in_opb;
   logic         in_opa_vld, in_opb_vld;
   logic [N-1:0] in_cmd;
   logic         in_mode, in_cin;
   logic         in_rdy_a, in_rdy_b;
   logic [W-1:0] OPA, OPB;
   logic [N-1:0] CMD;
   logic         mode, Cin;
   logic [1:0]   inp_valid;
   logic         issue, TMO;

   always #5 clk = ~clk;

   alu_operand_collector #(.W(W), .N(N)) dut (
      .clk(clk), .RST(RST), .CE(CE),
      .in_opa(in_opa), .in_opa_vld(in_opa_vld),
      .in_opb(in_opb), .in_opb_vld(in_opb_vld),
      .in_cmd(in_cmd), .in_mode(in_mode), .in_cin(in_cin),
      .in_rdy_a(in_rdy_a), .in_rdy_b(in_rdy_b),
      .OPA(OPA), .OPB(OPB), .CMD(CMD), .mode(mode), .Cin(Cin),
      .inp_valid(inp_valid), .issue(issue), .TMO(TMO)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: which operand slots are filled, and whether an issue is showing.
   bit           model_valid = 1'b0;
   bit           m_issuing, m_have_a, m_have_b;
   logic [W-1:0] m_a, m_b;
   logic [N-1:0] m_cmd;
   logic         m_mode, m_cin;
   int           m_wait;
   logic [W-1:0] e_opa, e_opb;
   logic [N-1:0] e_cmd;
   logic         e_mode, e_cin, e_issue, e_tmo;
   logic [1:0]   e_vld;

   function automatic void m_issue(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [1:0] v, input logic t);
      e_opa = a; e_opb = b; e_cmd = m_cmd; e_mode = m_mode; e_cin = m_cin;
      e_vld = v; e_tmo = t; e_issue = 1'b1;
      m_issuing = 1'b1; m_have_a = 1'b0; m_have_b = 1'b0;
   endfunction

   always @(posedge clk) begin
      bit ta, tb, waiting;
      if (!RST) begin
         model_valid = 1'b1;
         m_issuing = 0; m_have_a = 0; m_have_b = 0; m_wait = 0;
         m_a = '0; m_b = '0; m_cmd = '0; m_mode = 0; m_cin = 0;
         e_opa = '0; e_opb = '0; e_cmd = '0; e_mode = 0; e_cin = 0;
         e_vld = 2'b00; e_issue = 0; e_tmo = 0;
      end else if (CE && model_valid) begin
         if (m_issuing) begin
            m_issuing = 0; e_issue = 0; e_vld = 2'b00; e_tmo = 0;
         end else begin
            ta = in_opa_vld && !m_have_a;
            tb = in_opb_vld && !m_have_b;
            waiting = m_have_a ^ m_have_b;
            if ((ta || tb) && !waiting) begin
               m_cmd = in_cmd; m_mode = in_mode; m_cin = in_cin; m_wait = 0;
            end
            if (ta) begin m_have_a = 1; m_a = in_opa; end
            if (tb) begin m_have_b = 1; m_b = in_opb; end
            if (m_have_a && m_have_b) begin
               m_issue(m_a, m_b, 2'b11, 1'b0);
            end else if (waiting) begin
               m_wait++;
`ifdef COLLECT_TIMEOUT_EN
               if (m_wait == 16) begin
                  if (m_have_a) m_issue(m_a, '0, 2'b01, 1'b1);
                  else          m_issue('0, m_b, 2'b10, 1'b1);
               end
`endif
            end
         end
      end
   end

   always @(negedge clk) begin
      if (model_valid) begin
         check("issue", issue, e_issue);
         check("inp_valid", inp_valid, e_vld);
         check("TMO", TMO, e_tmo);
         check("OPA", OPA, e_opa);
         check("OPB", OPB, e_opb);
         check("CMD", CMD, e_cmd);
         check("mode", mode, e_mode);
         check("Cin", Cin, e_cin);
         check("in_rdy_a", in_rdy_a, RST && CE && !m_issuing && !m_have_a);
         check("in_rdy_b", in_rdy_b, RST && CE && !m_issuing && !m_have_b);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      in_opa_vld = 0; in_opb_vld = 0;
   endtask

   initial begin
      RST = 0; CE = 1; in_opa = '0; in_opb = '0; in_opa_vld = 0; in_opb_vld = 0;
      in_cmd = '0; in_mode = 0; in_cin = 0;
      step(); step();
      check("rst_issue", issue, 0);
      check("rst_inp_valid", inp_valid, 2'b00);
      check("rst_rdy_a", in_rdy_a, 0);
      RST = 1; #1;
      check("idle_rdy_a", in_rdy_a, 1);

      // Both operands together.
      in_opa = 8'h12; in_opb = 8'h34; in_opa_vld = 1; in_opb_vld = 1; in_cmd = 4'h0;
      step(); quiet();
      check("both_issue", issue, 1);
      check("both_vld", inp_valid, 2'b11);
      check("both_opa", OPA, 8'h12);
      check("both_opb", OPB, 8'h34);
      step();
      check("both_done", issue, 0);

      // A, then B three cycles later; command comes from A's edge.
      in_opa = 8'h05; in_opa_vld = 1; in_cmd = 4'h3; in_mode = 1;
      step(); quiet(); in_cmd = 4'h9; in_mode = 0;
      step(); step();
      in_opb = 8'h07; in_opb_vld = 1;
      step(); quiet();
      check("seq_issue", issue, 1);
      check("seq_vld", inp_valid, 2'b11);
      check("seq_cmd", CMD, 4'h3);
      check("seq_mode", mode, 1);
      check("seq_opb", OPB, 8'h07);
      step();

      // Reset while waiting for A.
      in_opb = 8'h66; in_opb_vld = 1; in_cmd = 4'h5;
      step(); quiet(); step();
      RST = 0; #1;
      check("rstw_rdy_a", in_rdy_a, 0);
      check("rstw_rdy_b", in_rdy_b, 0);
      step(); RST = 1;
      check("rstw_issue", issue, 0);
      check("rstw_opa", OPA, 0);
      check("rstw_cmd", CMD, 0);
      step();
      check("rstw_noissue", issue, 0);

      // Operands offered during ISSUE wait until IDLE.
      in_opa = 8'h11; in_opb = 8'h22; in_opa_vld = 1; in_opb_vld = 1;
      step();
      in_opa = 8'hAA; in_opb = 8'hBB;
      check("iss_rdy_a", in_rdy_a, 0);
      check("iss_rdy_b", in_rdy_b, 0);
      step();
      check("iss_idle", issue, 0);
      check("iss_hold_opa", OPA, 8'h11);
      step(); quiet();
      check("iss_next_opa", OPA, 8'hAA);
      check("iss_next_opb", OPB, 8'hBB);
      step();

      // CE low for five cycles while waiting for B.
      in_opa = 8'h21; in_opa_vld = 1;
      step(); quiet();
      step(); step(); step();
      CE = 0;
      for (int i = 0; i < 5; i++) begin
         #1 check("ce_rdy_b", in_rdy_b, 0);
         step();
      end
      CE = 1;
`ifdef COLLECT_TIMEOUT_EN
      for (int i = 0; i < 12; i++) step();
      check("slip_early", issue, 0);
      step();
      check("slip_issue", issue, 1);
      check("slip_vld", inp_valid, 2'b01);
      check("slip_tmo", TMO, 1);
      check("slip_opb", OPB, 0);
      step();

      in_opb = 8'h44; in_opb_vld = 1;
      step(); quiet();
      for (int i = 0; i < 15; i++) step();
      check("to_early", issue, 0);
      step();
      check("to_issue", issue, 1);
      check("to_vld", inp_valid, 2'b10);
      check("to_opa", OPA, 0);
      check("to_tmo", TMO, 1);
      step();

      in_opb = 8'h45; in_opb_vld = 1;
      step(); quiet();
      for (int i = 0; i < 15; i++) step();
      in_opa = 8'h46; in_opa_vld = 1;
      step(); quiet();
      check("late_vld", inp_valid, 2'b11);
      check("late_tmo", TMO, 0);
      check("late_opa", OPA, 8'h46);
      step();
`else
      for (int i = 0; i < 20; i++) step();
      check("nto_issue", issue, 0);
      check("nto_rdy_b", in_rdy_b, 1);
      in_opb = 8'h22; in_opb_vld = 1;
      step(); quiet();
      check("nto_done", issue, 1);
      check("nto_vld", inp_valid, 2'b11);
      step();
`endif

      for (int i = 0; i < 3000; i++) begin
         RST        = ($urandom_range(99) != 0);
         CE         = ($urandom_range(9) != 0);
         in_opa_vld = ($urandom_range(9) < 3);
         in_opb_vld = ($urandom_range(9) < 3);
         in_opa     = W'($urandom);
         in_opb     = W'($urandom);
         in_cmd     = N'($urandom);
         in_mode    = 1'($urandom);
         in_cin     = 1'($urandom);
         step();
      end
      RST = 1; CE = 1; quiet();
      step(); step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
